// File: rtl/conf_mem.sv
// conf_mem: CGRA sequencer configuration store.
// Streamed load port, then one-cycle-latency reads bounded by max.
module conf_mem #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_err,
   output logic [ADDR_W-1:0] max,
   output logic              loaded
);

   localparam int unsigned DEPTH = (2 ** ADDR_W) - 1;
   localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      LOADING = 2'd1,
      READY   = 2'd2
   } state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   wcnt_q;
   logic [ADDR_W-1:0]   wcnt_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   rd_data_q;
   logic                rd_valid_q;
   logic                rd_err_q;
   logic                accept;
   logic                full;
   logic                in_rng;
   logic                rd_ok;

   assign load_ready = (state_q != READY) && !clear;
   assign accept     = load_valid && load_ready;
   assign wcnt_d     = wcnt_q + 1'b1;
   assign full       = (wcnt_d == LAST_CNT);
   assign in_rng     = (rd_addr < wcnt_q);
   assign rd_ok      = (state_q == READY) && in_rng;

   // The last accepted beat (explicit or capacity) lands in READY.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
         wcnt_q  <= '0;
      end else if (clear) begin
         state_q <= EMPTY;
         wcnt_q  <= '0;
      end else begin
         unique case (state_q)
            EMPTY, LOADING: begin
               if (accept) begin
                  wcnt_q  <= wcnt_d;
                  state_q <= (load_last || full) ? READY : LOADING;
               end
            end
            READY: begin
               state_q <= READY;
            end
            default: begin
               state_q <= EMPTY;
               wcnt_q  <= '0;
            end
         endcase
      end
   end

   // Array has no reset; only the loaded prefix is ever readable.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[wcnt_q] <= load_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         if (rd_en && !clear) begin
            if (rd_ok) begin
               rd_data_q  <= mem_q[rd_addr];
               rd_valid_q <= 1'b1;
            end else begin
               rd_err_q <= 1'b1;
            end
         end
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_err   = rd_err_q;
   assign max      = wcnt_q;
   assign loaded   = (state_q == READY);

endmodule

// File: tb/tb_conf_mem.sv
// tb_conf_mem: directed vectors for conf_mem.
// Table-driven cycles plus reset and capacity sequences.
module tb_conf_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;
   logic        load_last;
   logic        rd_en;
   logic [9:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_err;
   logic [9:0]  max_w;
   logic        loaded;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   conf_mem #(.DATA_W(32), .ADDR_W(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_last  (load_last),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_err     (rd_err),
      .max        (max_w),
      .loaded     (loaded)
   );

   typedef struct {
      logic        clr;
      logic        lv;
      logic [31:0] ld;
      logic        ll;
      logic        re;
      logic [9:0]  ra;
      logic        e_lr;
      logic [31:0] e_rd;
      logic        e_rv;
      logic        e_re;
      logic [9:0]  e_max;
      logic        e_ld;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic clr, input logic lv, input logic [31:0] ld,
      input logic ll, input logic re, input logic [9:0] ra,
      input logic e_lr, input logic [31:0] e_rd, input logic e_rv,
      input logic e_re, input logic [9:0] e_max, input logic e_ld);
      vec_t v;
      v.clr = clr; v.lv = lv; v.ld = ld; v.ll = ll;
      v.re = re; v.ra = ra; v.e_lr = e_lr; v.e_rd = e_rd;
      v.e_rv = e_rv; v.e_re = e_re; v.e_max = e_max; v.e_ld = e_ld;
      return v;
   endfunction

   task automatic beat(input logic [31:0] d, input logic last);
      @(negedge clk);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = last;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic rd_once(input logic [9:0] a);
      @(negedge clk);
      rd_en   = 1'b1;
      rd_addr = a;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      check({tag, "_max"}, 32'(max_w), 32'd0);
      check({tag, "_loaded"}, 32'(loaded), 32'd0);
      check({tag, "_rd_data"}, rd_data, 32'd0);
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      check({tag, "_rd_err"}, 32'(rd_err), 32'd0);
      check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] rdx;
      logic [9:0]  lp [14];
      rst = 1'b0; clear = 1'b0; load_valid = 1'b0; load_data = '0;
      load_last = 1'b0; rd_en = 1'b0; rd_addr = '0;

      // Reset values, then reset abandons a partial load.
      @(negedge clk);
      @(negedge clk);
      chk_reset("por");
      rst = 1'b1;
      beat(32'h11, 1'b0);
      beat(32'h12, 1'b0);
      beat(32'h13, 1'b0);
      check("part_max", 32'(max_w), 32'd3);
      check("part_loaded", 32'(loaded), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 chk_reset("midrst");
      @(negedge clk);
      rst = 1'b1;
      beat(32'hC0, 1'b0);
      beat(32'hC1, 1'b1);
      check("reload_max", 32'(max_w), 32'd2);
      check("reload_loaded", 32'(loaded), 32'd1);
      rd_once(10'd1);
      check("reload_rd", rd_data, 32'hC1);
      check("reload_rv", 32'(rd_valid), 32'd1);

      // Table of single-cycle vectors.
      rdx = 32'hC1;
      vq.push_back(mk(1,0,0,0,0,0, 0,rdx,0,0,0,0));
      for (int i = 0; i < 5; i++)
         vq.push_back(mk(0,1,32'hA0+i,(i==4),(i==1),0,
                         1,rdx,0,(i==1),10'(i+1),(i==4)));
      for (int i = 0; i < 5; i++) begin
         rdx = 32'hA0 + i;
         vq.push_back(mk(0,0,0,0,1,10'(i), 0,rdx,1,0,5,1));
      end
      vq.push_back(mk(0,0,0,0,1,5, 0,rdx,0,1,5,1));
      vq.push_back(mk(0,0,0,0,0,0, 0,rdx,0,0,5,1));
      vq.push_back(mk(0,1,32'hFF,0,0,0, 0,rdx,0,0,5,1));
      rdx = 32'hA2;
      vq.push_back(mk(0,0,0,0,1,2, 0,rdx,1,0,5,1));
      vq.push_back(mk(1,0,0,0,1,1, 0,rdx,0,0,0,0));
      vq.push_back(mk(1,1,32'h55,0,0,0, 0,rdx,0,0,0,0));
      vq.push_back(mk(0,0,0,0,0,0, 1,rdx,0,0,0,0));
      for (int i = 0; i < 8; i++)
         vq.push_back(mk(0,1,32'hB0+i,(i==7),0,0,
                         1,rdx,0,0,10'(i+1),(i==7)));
      lp = '{0,1,2,3,4,5,6,2,3,4,5,6,7,2};
      for (int i = 0; i < 14; i++) begin
         rdx = 32'hB0 + 32'(lp[i]);
         vq.push_back(mk(0,0,0,0,1,lp[i], 0,rdx,1,0,8,1));
      end

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         clear = vq[i].clr; load_valid = vq[i].lv;
         load_data = vq[i].ld; load_last = vq[i].ll;
         rd_en = vq[i].re; rd_addr = vq[i].ra;
         #1;
         check($sformatf("v%0d_load_ready", i), 32'(load_ready),
               32'(vq[i].e_lr));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_rd_data", i), rd_data, vq[i].e_rd);
         check($sformatf("v%0d_rd_valid", i), 32'(rd_valid),
               32'(vq[i].e_rv));
         check($sformatf("v%0d_rd_err", i), 32'(rd_err),
               32'(vq[i].e_re));
         check($sformatf("v%0d_max", i), 32'(max_w), 32'(vq[i].e_max));
         check($sformatf("v%0d_loaded", i), 32'(loaded),
               32'(vq[i].e_ld));
      end
      @(negedge clk);
      clear = 1'b0; load_valid = 1'b0; load_last = 1'b0; rd_en = 1'b0;

      // Capacity fill: 1023 beats without load_last.
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1 clear = 1'b0;
      for (int i = 0; i < 1023; i++) begin
         @(negedge clk);
         load_valid = 1'b1;
         load_data  = 32'(i) ^ 32'h5A5A0000;
         load_last  = 1'b0;
         #1;
         if (i == 0 || i == 1022)
            check($sformatf("fill%0d_load_ready", i), 32'(load_ready), 32'd1);
         if (i == 1021)
            check("fill_not_ready_early", 32'(loaded), 32'd0);
         @(posedge clk);
         #1;
      end
      check("full_loaded", 32'(loaded), 32'd1);
      check("full_max", 32'(max_w), 32'd1023);
      @(negedge clk);
      load_data = 32'hDEAD_BEEF;
      #1 check("full_load_ready", 32'(load_ready), 32'd0);
      @(posedge clk);
      #1 check("full_max_hold", 32'(max_w), 32'd1023);
      load_valid = 1'b0;
      rd_once(10'd1022);
      check("full_rd_top", rd_data, 32'h5A5A03FE);
      check("full_rv_top", 32'(rd_valid), 32'd1);
      rd_once(10'd1023);
      check("full_rd_oob_err", 32'(rd_err), 32'd1);
      check("full_rd_oob_data", rd_data, 32'h5A5A03FE);
      rd_once(10'd0);
      check("full_rd_zero", rd_data, 32'h5A5A0000);
      check("full_rd_zero_err", 32'(rd_err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
